simon32_iter_ctrl: RTL and testbench
====================================

Name: simon32_iter_ctrl

Overview:
Iterative Simon32/64 encryption engine controller.
- Accepts one 32-bit plaintext block and one 64-bit key through a valid/ready handshake.
- Reuses a single 16-bit round datapath for 32 consecutive cycles and expands the key schedule on the fly.
- Presents the 32-bit ciphertext on a valid/ready output.
- Sits between the block-request interface and the downstream ciphertext consumer.

Parameters:
ROUNDS, 32, number of rounds executed per block (Simon32/64 requires 32; legal range 4..62).
CNT_W, 6, width of the round counter; must satisfy 2**CNT_W > ROUNDS.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  plaintext/key request valid.
in_ready  out  1  engine can accept a request this cycle.
in_pt  in  32  plaintext; [31:16] = x (high word), [15:0] = y (low word).
in_key  in  64  key words; [15:0] = k0, [31:16] = k1, [47:32] = k2, [63:48] = k3.
out_valid  out  1  ciphertext valid.
out_ready  in  1  consumer accepts ciphertext.
out_ct  out  32  ciphertext; [31:16] = x, [15:0] = y.
busy  out  1  high while in RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_ct = 0, round counter = 0, x/y/key registers = 0.
- States:
  - IDLE: in_ready = 1. On in_valid, load x/y from in_pt, load key regs kq[0..3] from k0..k3, clear the counter, and go to RUN.
  - RUN: in_ready = 0, busy = 1. Each cycle performs one round:
    - x' = (S1(x) & S8(x)) ^ S2(x) ^ y ^ kq[0]
    - y' = x
    - S^n is a 16-bit left rotate by n.
    - Concurrently the key queue shifts: kq[0..2] <= kq[1..3], kq[3] <= new word from the key step.
    - Counter increments. When counter == ROUNDS-1, the round still executes, the state goes to DONE and out_valid is set on the same edge.
  - DONE: out_valid = 1, out_ct = {x, y} held stable until out_ready.
    - On out_ready without in_valid: go to IDLE.
    - in_ready = out_ready in DONE. On out_ready & in_valid in the same cycle, the new request loads and the state goes straight to RUN, giving back-to-back blocks with no bubble.
- Key step (Simon32/64, m = 4):
  - t = R3(kq[3]) ^ kq[1]
  - t = t ^ R1(t)
  - new = ~kq[0] ^ t ^ z0[counter] ^ 16'h0003
  - R^n is a 16-bit right rotate by n. z0[counter] enters bit 0.
  - Words generated after round ROUNDS-5 are unused; this is harmless.
- z0 sequence: the 62-bit constant 11111010001001010110000111001101111101000100101011000011100110, where the leftmost bit is index 0.
- Latency: accept edge to out_valid = ROUNDS cycles (32). Throughput = one block per 33 cycles when out_ready is held high, or 32+1 with back-to-back loading.
- Handshake rules:
  - in_* is sampled only when in_valid & in_ready.
  - in_valid during RUN is ignored and not stored; the source must hold it.
  - out_ct is not updated while out_valid = 1 and out_ready = 0.
- Reset mid-operation: asserting rst_n low in any state aborts immediately to the reset values. The partial block is discarded and no out_valid is emitted.
- X/Z inputs in IDLE with in_valid = 0 must not disturb state.

Decomposition:
- Shared package simon_pkg holds:
  - Z0 (62-bit constant)
  - KEY_C (16'hFFFC)
  - WORD_W = 16, BLOCK_W = 32, KEY_W = 64
  - state enum {IDLE, RUN, DONE}
- Round datapath: instantiate the team's existing single-round combinational block (sigle_block: in_low = y, in_high = x, in_key = kq[0]).
- Natural sub-module: simon32_key_step, a combinational block with inputs kq0, kq1, kq3 and z bit, and output next key word.
- FSM, counter and registers stay in the top.

Test Plan:
1. Standard vector: in_key = 64'h1918_1110_0908_0100, in_pt = 32'h6565_6877, out_ready = 1 -> out_valid exactly 32 cycles after the accept edge with out_ct = 32'hc69b_e9bb, then in_ready = 1 the following cycle.
2. Output backpressure: vector 1 with out_ready = 0 for 10 cycles after out_valid -> out_ct stays 32'hc69b_e9bb, in_ready = 0 and in_valid is ignored; on out_ready = 1 it completes in one cycle.
3. Back-to-back: second request (same key, pt = 32'h0000_0000) held valid while the first is in DONE with out_ready = 1 -> the second loads on the same edge the first is consumed. Second out_valid comes 32 cycles later; out_ct must match the golden model.
4. Input during RUN: pulse in_valid with a different pt at round 10 -> not accepted (in_ready = 0); first result is still 32'hc69b_e9bb.
5. Reset mid-run: rst_n low at round 15 for 2 cycles -> out_valid = 0, in_ready = 1, busy = 0 immediately. Re-running vector 1 afterwards yields 32'hc69b_e9bb.
6. Random regression: 1000 random key/pt pairs with random out_ready stalls -> every out_ct matches the reference model, with no lost or duplicated outputs.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon32/64 iterative engine.
package simon_pkg;

    localparam int WORD_W  = 16;
    localparam int BLOCK_W = 32;
    localparam int KEY_W   = 64;

    // Leftmost bit is sequence index 0, so index i lives at bit 61-i.
    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    localparam logic [WORD_W-1:0] KEY_C = 16'hFFFC;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic z0_bit(input logic [5:0] idx);
        return Z0[6'd61 - idx];
    endfunction

endpackage

// File: rtl/sigle_block.sv
// One combinational Simon32 Feistel round: x' = f(x) ^ y ^ k, y' = x.
module sigle_block
    import simon_pkg::*;
(
    input  logic [WORD_W-1:0] in_high,
    input  logic [WORD_W-1:0] in_low,
    input  logic [WORD_W-1:0] in_key,
    output logic [WORD_W-1:0] out_high,
    output logic [WORD_W-1:0] out_low
);

    logic [WORD_W-1:0] rot1;
    logic [WORD_W-1:0] rot2;
    logic [WORD_W-1:0] rot8;

    assign rot1 = {in_high[14:0], in_high[15]};
    assign rot2 = {in_high[13:0], in_high[15:14]};
    assign rot8 = {in_high[7:0],  in_high[15:8]};

    assign out_high = (rot1 & rot8) ^ rot2 ^ in_low ^ in_key;
    assign out_low  = in_high;

endmodule

// File: rtl/simon32_key_step.sv
// Simon32/64 (m = 4) key-schedule step producing the next round-key word.
module simon32_key_step
    import simon_pkg::*;
(
    input  logic [WORD_W-1:0] kq0,
    input  logic [WORD_W-1:0] kq1,
    input  logic [WORD_W-1:0] kq3,
    input  logic              z_bit,
    output logic [WORD_W-1:0] key_next
);

    logic [WORD_W-1:0] t_a;
    logic [WORD_W-1:0] t_b;

    assign t_a = {kq3[2:0], kq3[15:3]} ^ kq1;
    assign t_b = t_a ^ {t_a[0], t_a[15:1]};

    // KEY_C ^ kq0 equals ~kq0 ^ 3.
    assign key_next = KEY_C ^ kq0 ^ t_b ^ {{(WORD_W-1){1'b0}}, z_bit};

endmodule

// File: rtl/simon32_iter_ctrl.sv
// Iterative Simon32/64 encryption engine: one round per cycle, key expanded on the fly.
module simon32_iter_ctrl
    import simon_pkg::*;
#(
    parameter int ROUNDS = 32,
    parameter int CNT_W  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BLOCK_W-1:0]   in_pt,
    input  logic [KEY_W-1:0]     in_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BLOCK_W-1:0]   out_ct,
    output logic                 busy
);

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic [WORD_W-1:0]           x_q;
    logic [WORD_W-1:0]           y_q;
    logic [3:0][WORD_W-1:0]      kq;
    logic [WORD_W-1:0]           round_x;
    logic [WORD_W-1:0]           round_y;
    logic [WORD_W-1:0]           key_next;
    logic                        z_bit;
    logic                        last_round;
    logic                        accept;

    sigle_block u_round (
        .in_high  (x_q),
        .in_low   (y_q),
        .in_key   (kq[0]),
        .out_high (round_x),
        .out_low  (round_y)
    );

    simon32_key_step u_key_step (
        .kq0      (kq[0]),
        .kq1      (kq[1]),
        .kq3      (kq[3]),
        .z_bit    (z_bit),
        .key_next (key_next)
    );

    assign z_bit      = z0_bit(6'(cnt));
    assign last_round = (cnt == CNT_W'(ROUNDS - 1));

    // DONE passes out_ready through so a waiting request loads as the result leaves.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign out_ct   = {x_q, y_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            kq        <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            x_q       <= in_pt[31:16];
            y_q       <= in_pt[15:0];
            kq        <= in_key;
            cnt       <= '0;
            state     <= RUN;
            busy      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    x_q <= round_x;
                    y_q <= round_y;
                    kq  <= {key_next, kq[3:1]};
                    cnt <= cnt + 1'b1;
                    if (last_round) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon32_iter_ctrl.sv
// Directed and random checks of simon32_iter_ctrl against a standalone Simon32/64 model.
module tb_simon32_iter_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pt;
    logic [63:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ct;
    logic        busy;

    int total;
    int bad;
    int n_in;
    int n_out;

    localparam logic [63:0] KEY1 = 64'h1918_1110_0908_0100;
    localparam logic [31:0] PT1  = 32'h6565_6877;
    localparam logic [31:0] CT1  = 32'hc69b_e9bb;

    simon32_iter_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pt     (in_pt),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ct    (out_ct),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready)
            n_in <= n_in + 1;
        if (rst_n && out_valid && out_ready)
            n_out <= n_out + 1;
    end

    function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
        return 16'((v << n) | (v >> (16 - n)));
    endfunction

    function automatic logic [15:0] ror16(input logic [15:0] v, input int n);
        return 16'((v >> n) | (v << (16 - n)));
    endfunction

    // Full key expansion up front, then 32 Feistel rounds.
    function automatic logic [31:0] ref_encrypt(input logic [63:0] key, input logic [31:0] pt);
        logic [15:0] k [0:31];
        logic [61:0] zseq;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] tmp;
        zseq = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++)
            k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp  = ror16(k[i-1], 3) ^ k[i-3];
            tmp  = tmp ^ ror16(tmp, 1);
            k[i] = ~k[i-4] ^ tmp ^ {15'b0, zseq[61-(i-4)]} ^ 16'h0003;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x   = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ k[i];
            y   = tmp;
        end
        return {x, y};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge while the engine is ready; returns one negedge after the accept edge.
    task automatic applyStimulus(input logic [63:0] key, input logic [31:0] pt);
        in_key   = key;
        in_pt    = pt;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitOut(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int stall;
        int dup;
        int in_base;
        int out_base;
        logic [63:0] rkey;
        logic [31:0] rpt;
        logic [31:0] exp_ct;

        total     = 0;
        bad       = 0;
        n_in      = 0;
        n_out     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pt     = '0;
        in_key    = '0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_ct", out_ct, 0);
        rst_n = 1'b1;
        tick();

        // Standard vector with the consumer always ready.
        out_ready = 1'b1;
        applyStimulus(KEY1, PT1);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_in_ready_run", in_ready, 0);
        waitOut(cyc);
        checkOutput("t1_latency", cyc, 32);
        checkOutput("t1_ct", out_ct, CT1);
        tick();
        checkOutput("t1_out_valid_drop", out_valid, 0);
        checkOutput("t1_in_ready_after", in_ready, 1);
        checkOutput("t1_busy_after", busy, 0);

        // Output backpressure with a competing request ignored.
        out_ready = 1'b0;
        applyStimulus(KEY1, PT1);
        waitOut(cyc);
        checkOutput("t2_latency", cyc, 32);
        in_valid = 1'b1;
        in_pt    = 32'h1234_5678;
        dup = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_ct !== CT1 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0)
                dup++;
            tick();
        end
        checkOutput("t2_hold_errors", dup, 0);
        checkOutput("t2_ct_held", out_ct, CT1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("t2_released", out_valid, 0);
        checkOutput("t2_in_ready", in_ready, 1);

        // Back-to-back: second request waits and loads on the consume edge.
        applyStimulus(KEY1, PT1);
        in_key   = KEY1;
        in_pt    = 32'h0000_0000;
        in_valid = 1'b1;
        waitOut(cyc);
        checkOutput("t3_first_latency", cyc, 32);
        checkOutput("t3_first_ct", out_ct, CT1);
        checkOutput("t3_in_ready_done", in_ready, 1);
        tick();
        in_valid = 1'b0;
        checkOutput("t3_second_busy", busy, 1);
        checkOutput("t3_second_no_valid", out_valid, 0);
        waitOut(cyc);
        checkOutput("t3_second_latency", cyc, 32);
        checkOutput("t3_second_ct", out_ct, ref_encrypt(KEY1, 32'h0000_0000));
        tick();

        // A request pulse during RUN is not taken.
        applyStimulus(KEY1, PT1);
        repeat (9) tick();
        in_valid = 1'b1;
        in_pt    = 32'hdead_beef;
        checkOutput("t4_in_ready_run", in_ready, 0);
        tick();
        in_valid = 1'b0;
        waitOut(cyc);
        checkOutput("t4_latency", cyc + 10, 32);
        checkOutput("t4_ct", out_ct, CT1);
        tick();

        // Reset in the middle of a block.
        applyStimulus(KEY1, PT1);
        repeat (14) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("t5_out_valid", out_valid, 0);
        checkOutput("t5_in_ready", in_ready, 1);
        checkOutput("t5_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("t5_ct_cleared", out_ct, 0);
        applyStimulus(KEY1, PT1);
        waitOut(cyc);
        checkOutput("t5_rerun_ct", out_ct, CT1);
        tick();

        // Random blocks with random consumer stalls.
        out_ready = 1'b0;
        in_base   = n_in;
        out_base  = n_out;
        dup       = 0;
        for (int it = 0; it < 1000; it++) begin
            rkey   = {$urandom, $urandom};
            rpt    = $urandom;
            exp_ct = ref_encrypt(rkey, rpt);
            applyStimulus(rkey, rpt);
            waitOut(cyc);
            if (cyc >= 100) begin
                checkOutput("rnd_timeout", cyc, 32);
                break;
            end
            stall = $urandom_range(0, 3);
            repeat (stall) tick();
            checkOutput("rnd_ct", out_ct, exp_ct);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (out_valid !== 1'b0)
                dup++;
        end
        checkOutput("rnd_no_dup", dup, 0);
        checkOutput("rnd_accepted", n_in - in_base, 1000);
        checkOutput("rnd_delivered", n_out - out_base, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
